// File: rtl/bfprocessor_pipe.sv
// Three-stage radix-2 butterfly: D = (A+B)k, E = W(A-B)k with optional halving or saturation.
// Valid/ready pipeline with one global advance enable and a sticky saturation flag.
module bfprocessor_pipe #(
  parameter int W  = 8,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  A_re,
  input  logic [W-1:0]  A_im,
  input  logic [W-1:0]  B_re,
  input  logic [W-1:0]  B_im,
  input  logic [TW-1:0] i_C,
  input  logic [TW:0]   C_plus_S,
  input  logic [TW:0]   C_minus_S,
  input  logic          i_scale,
  input  logic          i_ovf_clr,
  input  logic          i_out_ready,
  output logic          o_valid,
  output logic [W-1:0]  D_re,
  output logic [W-1:0]  D_im,
  output logic [W-1:0]  E_re,
  output logic [W-1:0]  E_im,
  output logic          o_ovf
);

  localparam int PW = W + TW + 1;
  localparam int RW = PW + 2;
  localparam logic [RW-1:0] RND = RW'(1) << (TW - 2);

  // Products are formed on operands sign-extended to PW bits, so the low PW bits
  // of an unsigned multiply equal the signed product; no signed types needed.
  function automatic logic [W:0] stage1_fit(input logic [W:0] v, input logic scale);
    if (scale) return {1'b0, v[W:1]};
    if (v[W] != v[W-1]) return {1'b1, v[W], {(W-1){~v[W]}}};
    return {1'b0, v[W-1:0]};
  endfunction

  function automatic logic [W:0] stage3_fit(input logic [RW-1:0] v);
    if ((&v[RW-1:W-1]) || !(|v[RW-1:W-1])) return {1'b0, v[W-1:0]};
    return {1'b1, v[RW-1], {(W-1){~v[RW-1]}}};
  endfunction

  logic en, take;
  assign en         = !o_valid || i_out_ready;
  assign o_in_ready = en;
  assign take       = i_valid && en;

  logic [W:0] sum_re, sum_im, dif_re, dif_im;
  logic [W:0] f_sre, f_sim, f_dre, f_dim;
  logic       sat1;
  assign sum_re = {A_re[W-1], A_re} + {B_re[W-1], B_re};
  assign sum_im = {A_im[W-1], A_im} + {B_im[W-1], B_im};
  assign dif_re = {A_re[W-1], A_re} - {B_re[W-1], B_re};
  assign dif_im = {A_im[W-1], A_im} - {B_im[W-1], B_im};
  assign f_sre  = stage1_fit(sum_re, i_scale);
  assign f_sim  = stage1_fit(sum_im, i_scale);
  assign f_dre  = stage1_fit(dif_re, i_scale);
  assign f_dim  = stage1_fit(dif_im, i_scale);
  assign sat1   = take && (f_sre[W] || f_sim[W] || f_dre[W] || f_dim[W]);

  logic          v1;
  logic [W-1:0]  d1_re, d1_im, x1, y1;
  logic [TW-1:0] c1;
  logic [TW:0]   cps1, cms1;

  logic [W:0]    xmy;
  logic [PW-1:0] t_n, p_n, q_n;
  assign xmy = {x1[W-1], x1} - {y1[W-1], y1};
  assign t_n = {{(W+1){c1[TW-1]}}, c1} * {{TW{xmy[W]}}, xmy};
  assign p_n = {{W{cms1[TW]}}, cms1} * {{(TW+1){y1[W-1]}}, y1};
  assign q_n = {{W{cps1[TW]}}, cps1} * {{(TW+1){x1[W-1]}}, x1};

  logic          v2;
  logic [W-1:0]  d2_re, d2_im;
  logic [PW-1:0] t2, p2, q2;

  logic [RW-1:0] re_r, im_r, re_sh, im_sh;
  logic [W:0]    f_ere, f_eim;
  logic          sat3;
  assign re_r  = {{2{t2[PW-1]}}, t2} + {{2{p2[PW-1]}}, p2} + RND;
  assign im_r  = {{2{q2[PW-1]}}, q2} - {{2{t2[PW-1]}}, t2} + RND;
  assign re_sh = {{(TW-1){re_r[RW-1]}}, re_r[RW-1:TW-1]};
  assign im_sh = {{(TW-1){im_r[RW-1]}}, im_r[RW-1:TW-1]};
  assign f_ere = stage3_fit(re_sh);
  assign f_eim = stage3_fit(im_sh);
  assign sat3  = v2 && en && (f_ere[W] || f_eim[W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      d1_re   <= '0;
      d1_im   <= '0;
      x1      <= '0;
      y1      <= '0;
      c1      <= '0;
      cps1    <= '0;
      cms1    <= '0;
      v2      <= 1'b0;
      d2_re   <= '0;
      d2_im   <= '0;
      t2      <= '0;
      p2      <= '0;
      q2      <= '0;
      o_valid <= 1'b0;
      D_re    <= '0;
      D_im    <= '0;
      E_re    <= '0;
      E_im    <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (en) begin
        v1      <= i_valid;
        d1_re   <= f_sre[W-1:0];
        d1_im   <= f_sim[W-1:0];
        x1      <= f_dre[W-1:0];
        y1      <= f_dim[W-1:0];
        c1      <= i_C;
        cps1    <= C_plus_S;
        cms1    <= C_minus_S;
        v2      <= v1;
        d2_re   <= d1_re;
        d2_im   <= d1_im;
        t2      <= t_n;
        p2      <= p_n;
        q2      <= q_n;
        o_valid <= v2;
        D_re    <= d2_re;
        D_im    <= d2_im;
        E_re    <= f_ere[W-1:0];
        E_im    <= f_eim[W-1:0];
      end
      // a fresh saturation event outranks the clear
      if (sat1 || sat3) o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfprocessor_pipe.sv
// Bench for bfprocessor_pipe: directed cases plus random traffic against a complex-arithmetic model.
module tb_bfprocessor_pipe;
  localparam int W  = 8;
  localparam int TW = 8;
  localparam int LO = -(1 << (W - 1));
  localparam int HI = (1 << (W - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, o_in_ready, i_scale, i_ovf_clr, i_out_ready, o_valid, o_ovf;
  logic [W-1:0]  A_re, A_im, B_re, B_im;
  logic [TW-1:0] i_C;
  logic [TW:0]   C_plus_S, C_minus_S;
  logic signed [W-1:0] D_re, D_im, E_re, E_im;

  bfprocessor_pipe #(.W(W), .TW(TW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .A_re(A_re), .A_im(A_im), .B_re(B_re), .B_im(B_im),
    .i_C(i_C), .C_plus_S(C_plus_S), .C_minus_S(C_minus_S),
    .i_scale(i_scale), .i_ovf_clr(i_ovf_clr), .i_out_ready(i_out_ready),
    .o_valid(o_valid), .D_re(D_re), .D_im(D_im), .E_re(E_re), .E_im(E_im),
    .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int dre, dim, ere, eim;
    bit s1, s3;
  } item_t;

  item_t slot[3];
  bit    m_ovf;
  int    n_chk = 0;
  int    n_err = 0;
  int    n_dut_out = 0;

  int ar, ai, br, bi, c, s;
  bit val, scl, clr, ordy;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampw(input int v);
    if (v > HI) return HI;
    if (v < LO) return LO;
    return v;
  endfunction

  // k-scaling: floor-halve, or saturate to W bits
  function automatic int kscale(input int v, input bit scale, inout bit sat);
    if (scale) return v >>> 1;
    if (clampw(v) != v) sat = 1'b1;
    return clampw(v);
  endfunction

  function automatic int qround(input int v, inout bit sat);
    int r;
    r = (v + (1 << (TW - 2))) >>> (TW - 1);
    if (clampw(r) != r) sat = 1'b1;
    return clampw(r);
  endfunction

  // D = (A+B)k ; E = (C + jS) * (A-B)k, computed as a plain complex product
  function automatic item_t ref_bf(input int a_r, a_i, b_r, b_i, cc, ss, input bit scale);
    item_t it;
    int x, y;
    bit sat1 = 1'b0, sat3 = 1'b0;
    it.v   = 1'b1;
    it.dre = kscale(a_r + b_r, scale, sat1);
    it.dim = kscale(a_i + b_i, scale, sat1);
    x      = kscale(a_r - b_r, scale, sat1);
    y      = kscale(a_i - b_i, scale, sat1);
    it.ere = qround(cc * x - ss * y, sat3);
    it.eim = qround(ss * x + cc * y, sat3);
    it.s1  = sat1;
    it.s3  = sat3;
    return it;
  endfunction

  task automatic drive();
    int cp, cm;
    cp = c + s;
    cm = c - s;
    i_valid     = val;
    A_re        = ar[W-1:0];
    A_im        = ai[W-1:0];
    B_re        = br[W-1:0];
    B_im        = bi[W-1:0];
    i_C         = c[TW-1:0];
    C_plus_S    = cp[TW:0];
    C_minus_S   = cm[TW:0];
    i_scale     = scl;
    i_ovf_clr   = clr;
    i_out_ready = ordy;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) slot[i] = '{default: 0};
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit    en, evt;
    item_t nw;
    en  = !slot[2].v || ordy;
    nw  = ref_bf(ar, ai, br, bi, c, s, scl);
    evt = en && ((val && nw.s1) || (slot[1].v && slot[1].s3));
    if (evt) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (en) begin
      slot[2] = slot[1];
      slot[1] = slot[0];
      if (val) slot[0] = nw;
      else slot[0] = '{default: 0};
    end
  endtask

  task automatic check_cycle();
    chk("o_valid", int'(o_valid), int'(slot[2].v));
    chk("o_in_ready", int'(o_in_ready), int'(!slot[2].v || ordy));
    chk("o_ovf", int'(o_ovf), int'(m_ovf));
    if (slot[2].v) begin
      chk("D_re", int'(D_re), slot[2].dre);
      chk("D_im", int'(D_im), slot[2].dim);
      chk("E_re", int'(E_re), slot[2].ere);
      chk("E_im", int'(E_im), slot[2].eim);
    end
    if (o_valid && ordy) n_dut_out++;
  endtask

  // one clock: present inputs, advance model at the edge, compare at the falling edge
  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic put(input int a_r, a_i, b_r, b_i, cc, ss, input bit scale);
    val = 1'b1; ar = a_r; ai = a_i; br = b_r; bi = b_i; c = cc; s = ss; scl = scale;
  endtask

  task automatic idle(input int n);
    val = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_o_valid"}, int'(o_valid), 0);
    chk({tag, "_in_ready"}, int'(o_in_ready), 1);
    chk({tag, "_o_ovf"}, int'(o_ovf), 0);
    chk({tag, "_D"}, int'({D_re, D_im}), 0);
    chk({tag, "_E"}, int'({E_re, E_im}), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero_outputs("reset");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    val = 0; ar = 0; ai = 0; br = 0; bi = 0; c = 0; s = 0; scl = 0; clr = 0; ordy = 1;
    model_clear();
    drive();
    #3;
    check_zero_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // halving, W = 1
    put(64, 0, 32, 0, 127, 0, 1'b1);
    step();
    idle(2);
    chk("r031_D_re", int'(D_re), 48);
    chk("r031_D_im", int'(D_im), 0);
    chk("r031_E_re", int'(E_re), 16);
    chk("r031_E_im", int'(E_im), 0);
    chk("r031_ovf", int'(o_ovf), 0);
    idle(1);

    // W = -j
    put(0, 0, -64, 0, 0, -127, 1'b1);
    step();
    idle(2);
    chk("r032_D_re", int'(D_re), -32);
    chk("r032_E_re", int'(E_re), 0);
    chk("r032_E_im", int'(E_im), -32);
    idle(1);

    // sum saturation and sticky flag
    put(127, 0, 127, 0, 127, 0, 1'b0);
    step();
    idle(2);
    chk("r033_D_re", int'(D_re), 127);
    chk("r033_E_re", int'(E_re), 0);
    chk("r033_ovf", int'(o_ovf), 1);
    idle(3);
    chk("r033_ovf_sticky", int'(o_ovf), 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("r033_ovf_cleared", int'(o_ovf), 0);

    // difference saturation propagates into E
    put(0, 0, -128, 0, 127, 0, 1'b0);
    step();
    idle(2);
    chk("r034_E_re", int'(E_re), 126);
    chk("r034_ovf", int'(o_ovf), 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;

    // clear and new saturation in the same cycle: set wins
    put(-128, 0, -128, 0, 64, 64, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_set_wins", int'(o_ovf), 1);
    idle(3);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;

    // four back-to-back, then a five-cycle stall
    base = n_dut_out;
    for (int i = 0; i < 4; i++) begin
      put(i * 20 - 30, 10 - i * 7, 5 * i, -3 * i, 90, -40 + i * 20, 1'(i & 1));
      step();
    end
    ordy = 1'b0;
    idle(5);
    chk("r035_in_ready_stall", int'(o_in_ready), 0);
    ordy = 1'b1;
    idle(6);
    chk("r035_count", n_dut_out - base, 4);

    // reset with two items in flight
    put(100, -50, 20, 7, 60, 30, 1'b1);
    step();
    put(-90, 33, 17, -8, -60, 70, 1'b0);
    step();
    do_reset();
    base = n_dut_out;
    idle(5);
    chk("r036_no_stale", n_dut_out - base, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      val  = ($urandom_range(9) < 7);
      ordy = ($urandom_range(3) != 0);
      clr  = ($urandom_range(19) == 0);
      scl  = 1'($urandom_range(1));
      ar   = int'($urandom_range(255)) - 128;
      ai   = int'($urandom_range(255)) - 128;
      br   = int'($urandom_range(255)) - 128;
      bi   = int'($urandom_range(255)) - 128;
      c    = int'($urandom_range(255)) - 128;
      s    = int'($urandom_range(255)) - 128;
      step();
      if (n == 300) do_reset();
    end
    val = 1'b0; ordy = 1'b1; clr = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
